// File: rtl/memory_map_pkg.sv
// Shared address-map constants, arbiter state encoding and requester port ids.
// Pure declarations: no logic, no latency, no flow control.
package memory_map_pkg;

    localparam int DEFAULT_DATA_WIDTH            = 32;
    localparam int DEFAULT_MEMORY_ADDRESS_WIDTH  = 13;
    localparam int DEFAULT_STORAGE_ADDRESS_WIDTH = 15;
    localparam int DEFAULT_STORAGE_LATENCY       = 4;

    localparam logic [31:0] MEMORY_END    = (32'd1 << DEFAULT_MEMORY_ADDRESS_WIDTH) - 32'd1;
    localparam logic [31:0] STORAGE_START = MEMORY_END + 32'd1;
    localparam logic [31:0] STORAGE_END   = STORAGE_START + (32'd1 << DEFAULT_STORAGE_ADDRESS_WIDTH) - 32'd1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        ERROR  = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } port_t;

endpackage

// File: rtl/memory_region_decode.sv
// Combinational address decode into memory / storage / out-of-map, with device-local addresses.
// Zero latency; no flow control.
module memory_region_decode
    import memory_map_pkg::*;
#(
    parameter int DATA_WIDTH            = DEFAULT_DATA_WIDTH,
    parameter int MEMORY_ADDRESS_WIDTH  = DEFAULT_MEMORY_ADDRESS_WIDTH,
    parameter int STORAGE_ADDRESS_WIDTH = DEFAULT_STORAGE_ADDRESS_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]            address,
    output logic                             is_memory,
    output logic                             is_storage,
    output logic                             is_error,
    output logic [MEMORY_ADDRESS_WIDTH-1:0]  memory_address,
    output logic [STORAGE_ADDRESS_WIDTH-1:0] storage_address
);

    // One extra bit keeps the region limits from overflowing the address width.
    localparam logic [DATA_WIDTH:0] STORAGE_BASE  = (DATA_WIDTH+1)'(1) << MEMORY_ADDRESS_WIDTH;
    localparam logic [DATA_WIDTH:0] STORAGE_LIMIT = STORAGE_BASE
                                                  + ((DATA_WIDTH+1)'(1) << STORAGE_ADDRESS_WIDTH)
                                                  - (DATA_WIDTH+1)'(1);

    logic [DATA_WIDTH:0] address_ext;

    assign address_ext     = {1'b0, address};
    assign is_memory       = address_ext < STORAGE_BASE;
    assign is_storage      = !is_memory && (address_ext <= STORAGE_LIMIT);
    assign is_error        = !is_memory && !is_storage;
    assign memory_address  = address[MEMORY_ADDRESS_WIDTH-1:0];
    assign storage_address = address[STORAGE_ADDRESS_WIDTH-1:0] - STORAGE_BASE[STORAGE_ADDRESS_WIDTH-1:0];

endmodule

// File: rtl/memory_access_arbiter.sv
// Round-robin arbiter sharing RAM and fixed-latency storage between fetch and data ports.
// Done at T+3 (memory), T+2+STORAGE_LATENCY (storage), T+2 (error); one transaction in flight, losers wait.
module memory_access_arbiter
    import memory_map_pkg::*;
#(
    parameter int DATA_WIDTH            = DEFAULT_DATA_WIDTH,
    parameter int MEMORY_ADDRESS_WIDTH  = DEFAULT_MEMORY_ADDRESS_WIDTH,
    parameter int STORAGE_ADDRESS_WIDTH = DEFAULT_STORAGE_ADDRESS_WIDTH,
    parameter int STORAGE_LATENCY       = DEFAULT_STORAGE_LATENCY
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             fetch_request,
    input  logic [DATA_WIDTH-1:0]            fetch_address,
    output logic                             fetch_done,
    output logic                             fetch_error,
    output logic [DATA_WIDTH-1:0]            fetch_data,
    input  logic                             data_request,
    input  logic                             data_write,
    input  logic [DATA_WIDTH-1:0]            data_address,
    input  logic [DATA_WIDTH-1:0]            data_write_data,
    output logic                             data_done,
    output logic                             data_error,
    output logic [DATA_WIDTH-1:0]            data_read_data,
    output logic [MEMORY_ADDRESS_WIDTH-1:0]  memory_address,
    output logic                             memory_write_enable,
    output logic [DATA_WIDTH-1:0]            memory_write_data,
    input  logic [DATA_WIDTH-1:0]            memory_read_data,
    output logic [STORAGE_ADDRESS_WIDTH-1:0] storage_address,
    output logic                             storage_enable,
    output logic                             storage_write_enable,
    output logic [DATA_WIDTH-1:0]            storage_write_data,
    input  logic [DATA_WIDTH-1:0]            storage_read_data
);

    localparam int COUNT_WIDTH = (STORAGE_LATENCY > 1) ? $clog2(STORAGE_LATENCY + 1) : 1;

    state_t                     state;
    state_t                     state_next;
    port_t                      pointer;
    port_t                      winner;
    port_t                      granted_port;
    logic                       grant_valid;
    logic                       granted_write;
    logic                       granted_storage;
    logic                       granted_error;
    logic [COUNT_WIDTH-1:0]     count;
    logic [DATA_WIDTH-1:0]      result;
    logic [DATA_WIDTH-1:0]      decode_address;

    logic                             dec_is_memory;
    logic                             dec_is_storage;
    logic                             dec_is_error;
    logic [MEMORY_ADDRESS_WIDTH-1:0]  dec_memory_address;
    logic [STORAGE_ADDRESS_WIDTH-1:0] dec_storage_address;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant_valid = fetch_request || data_request;
        winner      = pointer;
        if (fetch_request && !data_request) begin
            winner = FETCH;
        end else if (data_request && !fetch_request) begin
            winner = DATA;
        end
    end

    assign decode_address = (winner == DATA) ? data_address : fetch_address;

    memory_region_decode #(
        .DATA_WIDTH            (DATA_WIDTH),
        .MEMORY_ADDRESS_WIDTH  (MEMORY_ADDRESS_WIDTH),
        .STORAGE_ADDRESS_WIDTH (STORAGE_ADDRESS_WIDTH)
    ) u_decode (
        .address         (decode_address),
        .is_memory       (dec_is_memory),
        .is_storage      (dec_is_storage),
        .is_error        (dec_is_error),
        .memory_address  (dec_memory_address),
        .storage_address (dec_storage_address)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = dec_is_error ? ERROR : ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    if (count == '0) state_next = DONE;
            ERROR:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            pointer            <= DATA;
            granted_port       <= FETCH;
            granted_write      <= 1'b0;
            granted_storage    <= 1'b0;
            granted_error      <= 1'b0;
            count              <= '0;
            result             <= '0;
            memory_address     <= '0;
            memory_write_data  <= '0;
            storage_address    <= '0;
            storage_write_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        granted_port    <= winner;
                        pointer         <= (winner == DATA) ? FETCH : DATA;
                        granted_write   <= (winner == DATA) && data_write;
                        granted_storage <= dec_is_storage;
                        granted_error   <= dec_is_error;
                        if (dec_is_memory) begin
                            memory_address <= dec_memory_address;
                            if (winner == DATA) memory_write_data <= data_write_data;
                        end
                        if (dec_is_storage) begin
                            storage_address <= dec_storage_address;
                            if (winner == DATA) storage_write_data <= data_write_data;
                        end
                    end
                end
                ACCESS: begin
                    count <= granted_storage ? COUNT_WIDTH'(STORAGE_LATENCY - 1) : '0;
                end
                WAIT: begin
                    if (count == '0) begin
                        if (granted_write)        result <= '0;
                        else if (granted_storage) result <= storage_read_data;
                        else                      result <= memory_read_data;
                    end else begin
                        count <= count - COUNT_WIDTH'(1);
                    end
                end
                ERROR: begin
                    result <= '0;
                end
                default: ;
            endcase
        end
    end

    assign memory_write_enable  = (state == ACCESS) && !granted_storage && granted_write;
    assign storage_enable       = (state == ACCESS) && granted_storage;
    assign storage_write_enable = storage_enable && granted_write;

    assign fetch_done     = (state == DONE) && (granted_port == FETCH);
    assign fetch_error    = fetch_done && granted_error;
    assign fetch_data     = fetch_done ? result : '0;
    assign data_done      = (state == DONE) && (granted_port == DATA);
    assign data_error     = data_done && granted_error;
    assign data_read_data = data_done ? result : '0;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter with behavioural RAM and fixed-latency storage models.
module tb_memory_access_arbiter;

    localparam int DW  = 32;
    localparam int MAW = 13;
    localparam int SAW = 15;
    localparam int LAT = 4;

    logic           clock;
    logic           reset;
    logic           fetch_request;
    logic [DW-1:0]  fetch_address;
    logic           fetch_done;
    logic           fetch_error;
    logic [DW-1:0]  fetch_data;
    logic           data_request;
    logic           data_write;
    logic [DW-1:0]  data_address;
    logic [DW-1:0]  data_write_data;
    logic           data_done;
    logic           data_error;
    logic [DW-1:0]  data_read_data;
    logic [MAW-1:0] memory_address;
    logic           memory_write_enable;
    logic [DW-1:0]  memory_write_data;
    logic [DW-1:0]  memory_read_data;
    logic [SAW-1:0] storage_address;
    logic           storage_enable;
    logic           storage_write_enable;
    logic [DW-1:0]  storage_write_data;
    logic [DW-1:0]  storage_read_data;

    memory_access_arbiter #(
        .DATA_WIDTH            (DW),
        .MEMORY_ADDRESS_WIDTH  (MAW),
        .STORAGE_ADDRESS_WIDTH (SAW),
        .STORAGE_LATENCY       (LAT)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .fetch_request        (fetch_request),
        .fetch_address        (fetch_address),
        .fetch_done           (fetch_done),
        .fetch_error          (fetch_error),
        .fetch_data           (fetch_data),
        .data_request         (data_request),
        .data_write           (data_write),
        .data_address         (data_address),
        .data_write_data      (data_write_data),
        .data_done            (data_done),
        .data_error           (data_error),
        .data_read_data       (data_read_data),
        .memory_address       (memory_address),
        .memory_write_enable  (memory_write_enable),
        .memory_write_data    (memory_write_data),
        .memory_read_data     (memory_read_data),
        .storage_address      (storage_address),
        .storage_enable       (storage_enable),
        .storage_write_enable (storage_write_enable),
        .storage_write_data   (storage_write_data),
        .storage_read_data    (storage_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Storage read data is only non-zero exactly LAT cycles after a read strobe.
    logic [DW-1:0] ram      [0:(1<<MAW)-1];
    logic [DW-1:0] sto      [0:(1<<SAW)-1];
    logic [DW-1:0] sto_pipe [0:LAT-1];
    logic [DW-1:0] sto_salt;

    always @(posedge clock) begin
        memory_read_data <= ram[memory_address];
        if (memory_write_enable) ram[memory_address] <= memory_write_data;
        if (storage_enable && storage_write_enable) sto[storage_address] <= storage_write_data;
        sto_pipe[0] <= (storage_enable && !storage_write_enable) ? (sto[storage_address] ^ sto_salt) : '0;
        for (int i = 1; i < LAT; i++) sto_pipe[i] <= sto_pipe[i-1];
    end
    assign storage_read_data = sto_pipe[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    int          r_lat, r_sen, r_sen_cyc, r_swe, r_mwe, r_wrong;
    logic [31:0] r_dat, r_saddr, r_swd, r_mwd, r_maddr;
    logic        r_err;

    // Starts in an IDLE cycle, returns in the next IDLE cycle.
    task automatic xact(input logic on_data, input logic wr, input logic [31:0] addr, input logic [31:0] wdat);
        if (on_data) begin
            data_request = 1'b1; data_write = wr; data_address = addr; data_write_data = wdat;
        end else begin
            fetch_request = 1'b1; fetch_address = addr;
        end
        r_lat = 0; r_sen = 0; r_sen_cyc = 0; r_swe = 0; r_mwe = 0; r_wrong = 0;
        r_dat = '0; r_saddr = '0; r_swd = '0; r_mwd = '0; r_maddr = '0; r_err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock); #1;
            if (storage_enable) begin
                r_sen++; r_sen_cyc = n; r_saddr = 32'(storage_address); r_swd = storage_write_data;
                if (storage_write_enable) r_swe++;
            end
            if (memory_write_enable) begin
                r_mwe++; r_mwd = memory_write_data;
            end
            if (on_data ? fetch_done : data_done) r_wrong++;
            if (on_data ? data_done : fetch_done) begin
                r_lat   = n;
                r_dat   = on_data ? data_read_data : fetch_data;
                r_err   = on_data ? data_error : fetch_error;
                r_maddr = 32'(memory_address);
                break;
            end
        end
        if (r_lat == 0) check_val("timeout", 32'd0, 32'd1);
        data_request = 1'b0; fetch_request = 1'b0; data_write = 1'b0;
        @(posedge clock); #1;
    endtask

    int          k, both, lat;
    int          d_cyc  [0:3];
    logic        d_port [0:3];
    logic [31:0] d_dat  [0:3];

    initial begin
        reset = 1'b0; sto_salt = '0;
        fetch_request = 1'b0; fetch_address = '0;
        data_request = 1'b0; data_write = 1'b0; data_address = '0; data_write_data = '0;

        repeat (2) @(posedge clock);
        #1;
        check_val("rst_flags", {fetch_done, data_done, fetch_error, data_error}, 32'h0);
        check_val("rst_strobes", {memory_write_enable, storage_enable, storage_write_enable}, 32'h0);
        check_val("rst_rdata", fetch_data | data_read_data, 32'h0);
        check_val("rst_addr", {memory_address, storage_address}, 32'h0);
        check_val("rst_wdata", memory_write_data | storage_write_data, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        xact(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check_val("mwr_lat", r_lat, 3);
        check_val("mwr_we", r_mwe, 1);
        check_val("mwr_wd", r_mwd, 32'hDEAD_BEEF);
        check_val("mwr_rdata", r_dat, 32'h0);

        xact(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_val("mrd_lat", r_lat, 3);
        check_val("mrd_data", r_dat, 32'hDEAD_BEEF);
        check_val("mrd_maddr", r_maddr, 32'h0010);
        check_val("mrd_no_sen", r_sen, 0);
        check_val("mrd_err", r_err, 0);

        xact(1'b1, 1'b1, 32'h0000_2005, 32'h1234_5678);
        check_val("swr_sen", r_sen, 1);
        check_val("swr_sen_cyc", r_sen_cyc, 1);
        check_val("swr_swe", r_swe, 1);
        check_val("swr_saddr", r_saddr, 32'h0005);
        check_val("swr_wd", r_swd, 32'h1234_5678);
        check_val("swr_lat", r_lat, 6);
        check_val("swr_rdata", r_dat, 32'h0);

        xact(1'b1, 1'b1, 32'h0000_1FFF, 32'h1111_1111);
        check_val("b1fff_wr_mwe", r_mwe, 1);
        xact(1'b0, 1'b0, 32'h0000_1FFF, 32'h0);
        check_val("b1fff_lat", r_lat, 3);
        check_val("b1fff_data", r_dat, 32'h1111_1111);
        check_val("b1fff_maddr", r_maddr, 32'h1FFF);
        check_val("b1fff_wrong", r_wrong, 0);

        xact(1'b1, 1'b1, 32'h0000_2000, 32'hA5A5_0000);
        check_val("b2000_wr_saddr", r_saddr, 32'h0000);
        xact(1'b1, 1'b0, 32'h0000_2000, 32'h0);
        check_val("b2000_lat", r_lat, 6);
        check_val("b2000_data", r_dat, 32'hA5A5_0000);
        check_val("b2000_saddr", r_saddr, 32'h0000);

        xact(1'b1, 1'b1, 32'h0000_9FFF, 32'h5A5A_7FFF);
        check_val("b9fff_wr_saddr", r_saddr, 32'h7FFF);
        xact(1'b0, 1'b0, 32'h0000_9FFF, 32'h0);
        check_val("b9fff_lat", r_lat, 6);
        check_val("b9fff_data", r_dat, 32'h5A5A_7FFF);

        xact(1'b1, 1'b0, 32'h0000_A000, 32'h0);
        check_val("ba000_err", r_err, 1);
        check_val("ba000_lat", r_lat, 2);
        check_val("ba000_strobes", r_sen + r_mwe, 0);
        check_val("ba000_rdata", r_dat, 32'h0);
        xact(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        check_val("fetch_err", r_err, 1);
        check_val("fetch_err_lat", r_lat, 2);

        xact(1'b1, 1'b1, 32'h0000_0030, 32'h3030_3030);
        xact(1'b1, 1'b1, 32'h0000_0040, 32'h4040_4040);
        xact(1'b1, 1'b1, 32'h0000_2010, 32'h600D_D00D);

        // Both ports hold requests from the first cycle after reset.
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        fetch_request = 1'b1; fetch_address = 32'h0000_0030;
        data_request = 1'b1; data_write = 1'b0; data_address = 32'h0000_0040;
        k = 0; both = 0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clock); #1;
            if (fetch_done && data_done) both++;
            if ((fetch_done || data_done) && k < 4) begin
                d_port[k] = data_done;
                d_cyc[k]  = n;
                d_dat[k]  = data_done ? data_read_data : fetch_data;
                k++;
            end
        end
        fetch_request = 1'b0; data_request = 1'b0;
        @(posedge clock); #1;
        check_val("rr_count", k, 4);
        check_val("rr_both", both, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < k) begin
                check_val($sformatf("rr_port%0d", i), d_port[i], (i % 2 == 0) ? 1 : 0);
                check_val($sformatf("rr_cyc%0d", i), d_cyc[i], 3 + 4 * i);
                check_val($sformatf("rr_data%0d", i), d_dat[i], (i % 2 == 0) ? 32'h4040_4040 : 32'h3030_3030);
            end
        end

        // Reset lands in storage WAIT; the abandoned read must never surface.
        fetch_request = 1'b1; fetch_address = 32'h0000_2010;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_val("midrst_flags", {fetch_done, data_done, fetch_error, data_error}, 32'h0);
        check_val("midrst_strobes", {memory_write_enable, storage_enable, storage_write_enable}, 32'h0);
        check_val("midrst_addr", {memory_address, storage_address}, 32'h0);
        check_val("midrst_rdata", fetch_data | data_read_data, 32'h0);
        sto_salt = 32'hFFFF_0000;
        @(posedge clock); #1;
        reset = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock); #1;
            if (fetch_done) begin
                lat = n;
                check_val("post_rst_data", fetch_data, 32'h9FF2_D00D);
                break;
            end
        end
        check_val("post_rst_lat", lat, 6);
        fetch_request = 1'b0;
        @(posedge clock); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
